// File: rtl/clk_mon_pkg.sv
// Shared defaults and helpers for the divided-clock monitor.
package clk_mon_pkg;
  localparam int DEF_EXP_PERIOD = 6;
  localparam int DEF_EXP_HIGH   = 3;
  localparam int DEF_TOL        = 1;
  localparam int DEF_LOCK_CNT   = 4;
  localparam int DEF_TIMEOUT    = 64;

  function automatic int unsigned abs_diff(input int unsigned a, input int unsigned b);
    return (a > b) ? (a - b) : (b - a);
  endfunction
endpackage

// File: rtl/clk_div_monitor_edge_sync.sv
// Synchronizes the divided clock into clk_i and emits registered rise/fall strobes.
module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic              prev;
  logic              s;

  assign s = sync[STAGES-1];

  always_ff @(posedge clk_i) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= STAGES'({sync, d});
      prev <= s;
      rise <= s & ~prev;
      fall <= ~s & prev;
    end
  end
endmodule

// File: rtl/clk_div_monitor.sv
// Measures period/high time of a sampled divided clock; reports lock, stall and errors.
module clk_div_monitor
  import clk_mon_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CW          = 8,
  parameter int EXP_PERIOD  = DEF_EXP_PERIOD,
  parameter int EXP_HIGH    = DEF_EXP_HIGH,
  parameter int TOL         = DEF_TOL,
  parameter int LOCK_CNT    = DEF_LOCK_CNT,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic          clk_i,
  input  logic          rst,
  input  logic          div_clk_i,
  input  logic          clr_i,
  output logic          rise_o,
  output logic          fall_o,
  output logic [CW-1:0] period_o,
  output logic [CW-1:0] high_o,
  output logic          meas_valid_o,
  output logic          locked_o,
  output logic          stalled_o,
  output logic          err_o
);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] TO_C    = CW'(TIMEOUT);
  localparam int unsigned   EP_U    = EXP_PERIOD;
  localparam int unsigned   EH_U    = EXP_HIGH;
  localparam int unsigned   TOL_U   = TOL;

  logic          rise_r, fall_r;
  logic [CW-1:0] cnt, high_nxt;
  logic [MW-1:0] match_cnt;
  logic          armed, seen, fell;
  logic          arise, meas, good, err_set;

  edge_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i(clk_i),
    .rst  (rst),
    .d    (div_clk_i),
    .rise (rise_r),
    .fall (fall_r)
  );

  // Rises before the first fall are not trusted as a period start, so they are hidden too.
  assign arise   = rise_r & armed;
  assign rise_o  = arise;
  assign fall_o  = fall_r;
  assign meas    = arise & seen & fell;
  assign good    = (abs_diff(32'(cnt), EP_U) <= TOL_U) &&
                   (abs_diff(32'(high_nxt), EH_U) <= TOL_U);
  assign err_set = (meas & ~good) | (arise & seen & ~fell);

  always_ff @(posedge clk_i) begin
    if (rst) begin
      cnt          <= '0;
      high_nxt     <= '0;
      match_cnt    <= '0;
      armed        <= 1'b0;
      seen         <= 1'b0;
      fell         <= 1'b0;
      period_o     <= '0;
      high_o       <= '0;
      meas_valid_o <= 1'b0;
      locked_o     <= 1'b0;
      stalled_o    <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      meas_valid_o <= 1'b0;
      if (arise)               cnt <= CW'(1);
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;

      if (fall_r) begin
        armed <= 1'b1;
        fell  <= 1'b1;
        if (seen) high_nxt <= cnt;
      end

      if (arise) begin
        seen      <= 1'b1;
        fell      <= 1'b0;
        stalled_o <= 1'b0;
        if (meas) begin
          period_o     <= cnt;
          high_o       <= high_nxt;
          meas_valid_o <= 1'b1;
          if (good) begin
            if (int'(match_cnt) < LOCK_CNT) match_cnt <= match_cnt + 1'b1;
            locked_o <= (int'(match_cnt) + 1 >= LOCK_CNT);
          end else begin
            match_cnt <= '0;
            locked_o  <= 1'b0;
          end
        end
      end else if (cnt == TO_C) begin
        // Stall drops all history; the next period start must re-arm from a fall.
        stalled_o <= 1'b1;
        locked_o  <= 1'b0;
        match_cnt <= '0;
        seen      <= 1'b0;
        armed     <= 1'b0;
      end

      if (err_set)    err_o <= 1'b1;
      else if (clr_i) err_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench: phases of divider waveforms with hand-computed end-of-phase expectations.
module tb_clk_div_monitor;
  logic       clk_i = 1'b0;
  logic       rst, div_clk_i, clr_i;
  logic       rise_o, fall_o, meas_valid_o, locked_o, stalled_o, err_o;
  logic [7:0] period_o, high_o;

  int checks = 0;
  int failures = 0;

  clk_div_monitor dut (
    .clk_i       (clk_i),
    .rst         (rst),
    .div_clk_i   (div_clk_i),
    .clr_i       (clr_i),
    .rise_o      (rise_o),
    .fall_o      (fall_o),
    .period_o    (period_o),
    .high_o      (high_o),
    .meas_valid_o(meas_valid_o),
    .locked_o    (locked_o),
    .stalled_o   (stalled_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string name;
    int per, hi, alt, ph0, ncyc, clr;
    int e_per, e_hi, e_lock, e_err, e_stall;
    int e_lock_at, e_first_meas, e_stall_clr, e_hold, e_rise_after_fall;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic int outs_packed();
    return int'({rise_o, fall_o, period_o, high_o, meas_valid_o, locked_o, stalled_o, err_o});
  endfunction

  task automatic run_vec(input vec_t v);
    int ph, pidx, hi_j, nmeas, lock_at, first_meas, stall_clr, first_rise, first_fall;
    int lock_dropped, prev_st;
    ph = v.ph0; pidx = 0; nmeas = 0; lock_at = 0;
    first_meas = -1; stall_clr = -1; first_rise = -1; first_fall = -1;
    lock_dropped = 0; prev_st = int'(stalled_o);
    for (int i = 0; i < v.ncyc; i++) begin
      hi_j = (v.alt != 0 && pidx[0]) ? v.hi - 1 : v.hi;
      rst = 1'b0;
      div_clk_i = (v.per == 0) ? 1'b0 : (ph < hi_j);
      clr_i = (v.clr != 0 && i == 0);
      tick();
      if (meas_valid_o) begin
        nmeas++;
        if (first_meas < 0) first_meas = i;
        if (locked_o && lock_at == 0) lock_at = nmeas;
      end
      if (!locked_o) lock_dropped = 1;
      if (prev_st == 1 && !stalled_o && stall_clr < 0) stall_clr = i;
      prev_st = int'(stalled_o);
      if (rise_o && first_rise < 0) first_rise = i;
      if (fall_o && first_fall < 0) first_fall = i;
      if (v.clr != 0 && i == 0) chk({v.name, ".clr_err"}, int'(err_o), 0);
      if (v.per == 0 && i == 40) chk({v.name, ".no_early_stall"}, int'(stalled_o), 0);
      if (v.per != 0) begin
        ph++;
        if (ph == v.per) begin ph = 0; pidx++; end
      end
    end
    clr_i = 1'b0;
    chk({v.name, ".period"},  int'(period_o),  v.e_per);
    chk({v.name, ".high"},    int'(high_o),    v.e_hi);
    chk({v.name, ".locked"},  int'(locked_o),  v.e_lock);
    chk({v.name, ".err"},     int'(err_o),     v.e_err);
    chk({v.name, ".stalled"}, int'(stalled_o), v.e_stall);
    if (v.e_lock_at > 0)     chk({v.name, ".lock_at_meas"}, lock_at, v.e_lock_at);
    if (v.e_first_meas >= 0) chk({v.name, ".first_meas"}, first_meas, v.e_first_meas);
    if (v.e_stall_clr >= 0)  chk({v.name, ".stall_clr"}, stall_clr, v.e_stall_clr);
    if (v.e_hold != 0)       chk({v.name, ".lock_held"}, lock_dropped, 0);
    if (v.e_rise_after_fall != 0)
      chk({v.name, ".rise_after_fall"}, int'(first_fall >= 0 && first_rise > first_fall), 1);
  endtask

  initial begin
    //          name         per hi alt ph0 ncyc clr  per hi lk er st  lkat fm  sc hold raf
    vecs[0] = '{"clean6",     6, 3, 0, 0, 48, 0,    6, 3, 1, 0, 0,   4, 15, -1, 0, 1};
    vecs[1] = '{"alt23",      6, 3, 1, 0, 30, 0,    6, 2, 1, 0, 0,   0, -1, -1, 1, 0};
    vecs[2] = '{"per9",       9, 4, 0, 0, 18, 0,    9, 4, 0, 1, 0,   0, -1, -1, 0, 0};
    vecs[3] = '{"clr_reerr",  9, 4, 0, 0, 18, 1,    9, 4, 0, 1, 0,   0, -1, -1, 0, 0};
    vecs[4] = '{"stall",      0, 0, 0, 0, 70, 0,    9, 4, 0, 1, 1,   0, -1, -1, 0, 0};
    vecs[5] = '{"restart",    6, 3, 0, 0, 48, 1,    6, 3, 1, 0, 0,   4, 15,  9, 0, 0};
    vecs[6] = '{"rst_high",   6, 3, 0, 1, 47, 0,    6, 3, 1, 0, 0,   4, 14, -1, 0, 1};

    rst = 1'b1; div_clk_i = 1'b0; clr_i = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", outs_packed(), 0);

    for (int k = 0; k < 6; k++) run_vec(vecs[k]);

    // Reset while locked, with the divided clock high through release.
    rst = 1'b1; div_clk_i = 1'b1;
    tick();
    chk("rst_immediate", outs_packed(), 0);
    tick();
    chk("rst_hold", outs_packed(), 0);
    run_vec(vecs[6]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
